// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame arbiter slice.
package fft_pkg;

  // Input-side FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2
  } fsm_state_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Samples per FFT frame.
  function automatic int fft_max(input int total_step);
    return 1 << total_step;
  endfunction

  // Width of a channel tag, never below one bit.
  function automatic int tag_w(input int num_ch);
    return (num_ch < 2) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/fft_tag_fifo.sv
// Synchronous FIFO of channel tags for frames currently inside the FFT core.
module fft_tag_fifo
  import fft_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic         iclk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_tag,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH < 2) ? 1 : clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en, rd_en;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot.
  always_comb begin
    wr_en    = push && (!full || pop);
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en && !rd_en) cnt_d = cnt_q + (AW+1)'(1);
    if (!wr_en && rd_en) cnt_d = cnt_q - (AW+1)'(1);
  end

  // Pointer and occupancy state.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Tag storage, no reset needed since occupancy gates every read.
  always_ff @(posedge iclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/fft_frame_arbiter.sv
// Whole-frame round-robin arbiter sharing one FFT core among NUM_CH channels,
// tagging frames in flight and steering results back to their owner.
module fft_frame_arbiter
  import fft_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int TOTAL_STEP = 6,
  parameter int DATA_WIDTH = 16,
  parameter int FRAME_GAP  = 0,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                           iclk,
  input  logic                           rstn,
  input  logic [NUM_CH-1:0]              req,
  output logic [NUM_CH-1:0]              gnt,
  output logic [NUM_CH-1:0]              rd,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_real,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_imag,
  output logic                           core_ien,
  output logic [DATA_WIDTH-1:0]          core_real,
  output logic [DATA_WIDTH-1:0]          core_imag,
  input  logic                           core_oen,
  input  logic [DATA_WIDTH-1:0]          core_oreal,
  input  logic [DATA_WIDTH-1:0]          core_oimag,
  output logic                           o_valid,
  output logic [tag_w(NUM_CH)-1:0]       o_ch,
  output logic                           o_sof,
  output logic                           o_eof,
  output logic [DATA_WIDTH-1:0]          o_real,
  output logic [DATA_WIDTH-1:0]          o_imag,
  output logic                           busy,
  output logic                           err_orphan
);

  localparam int N  = fft_max(TOTAL_STEP);
  localparam int CW = tag_w(NUM_CH);
  localparam int GW = (FRAME_GAP < 2) ? 1 : clog2(FRAME_GAP);

  // Input-side state
  fsm_state_e             state_q, state_d;
  logic [CW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]          gch_q, gch_d;
  logic [TOTAL_STEP-1:0]  in_cnt_q, in_cnt_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0]      gnt_q, gnt_d;
  logic [NUM_CH-1:0]      rd_q, rd_d;
  logic                   tag_push;
  logic                   pick_vld;
  logic [CW-1:0]          pick;

  // Core input register
  logic                   core_ien_q, core_ien_d;
  logic [DATA_WIDTH-1:0]  core_real_q, core_real_d;
  logic [DATA_WIDTH-1:0]  core_imag_q, core_imag_d;
  logic [DATA_WIDTH-1:0]  ch_real_a [NUM_CH];
  logic [DATA_WIDTH-1:0]  ch_imag_a [NUM_CH];

  // Output-side state
  logic [TOTAL_STEP-1:0]  out_cnt_q, out_cnt_d;
  logic                   o_valid_q, o_valid_d;
  logic [CW-1:0]          o_ch_q, o_ch_d;
  logic                   o_sof_q, o_sof_d;
  logic                   o_eof_q, o_eof_d;
  logic [DATA_WIDTH-1:0]  o_real_q, o_real_d;
  logic [DATA_WIDTH-1:0]  o_imag_q, o_imag_d;
  logic                   err_orphan_q, err_orphan_d;
  logic                   tag_pop;

  // Tag FIFO
  logic [CW-1:0]          tag_head;
  logic                   tag_full, tag_empty;

  fft_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (CW)
  ) u_tag_fifo (
    .iclk     (iclk),
    .rstn     (rstn),
    .push     (tag_push),
    .push_tag (gch_q),
    .pop      (tag_pop),
    .head     (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
    assign ch_real_a[k] = ch_real[k*DATA_WIDTH +: DATA_WIDTH];
    assign ch_imag_a[k] = ch_imag[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester at or after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!pick_vld && req[(int'(ptr_q) + i) % NUM_CH]) begin
        pick_vld = 1'b1;
        pick     = CW'((int'(ptr_q) + i) % NUM_CH);
      end
    end
  end

  // Frame FSM next state: grant in IDLE, stream N samples, optional gap.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gch_d     = gch_q;
    in_cnt_d  = in_cnt_q;
    gap_cnt_d = gap_cnt_q;
    gnt_d     = gnt_q;
    rd_d      = rd_q;
    tag_push  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld && !tag_full) begin
          state_d  = ST_STREAM;
          gch_d    = pick;
          in_cnt_d = '0;
          gnt_d    = NUM_CH'(1) << pick;
          rd_d     = NUM_CH'(1) << pick;
        end
      end
      ST_STREAM: begin
        in_cnt_d = in_cnt_q + TOTAL_STEP'(1);
        if (in_cnt_q == TOTAL_STEP'(N-1)) begin
          tag_push  = 1'b1;
          ptr_d     = (gch_q == CW'(NUM_CH-1)) ? '0 : gch_q + CW'(1);
          gnt_d     = '0;
          rd_d      = '0;
          in_cnt_d  = '0;
          gap_cnt_d = '0;
          state_d   = (FRAME_GAP > 0) ? ST_GAP : ST_IDLE;
        end
      end
      ST_GAP: begin
        gap_cnt_d = gap_cnt_q + GW'(1);
        if (gap_cnt_q == GW'(FRAME_GAP-1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core input: forward the granted channel's sample one cycle later.
  always_comb begin
    core_ien_d  = |rd_q;
    core_real_d = core_real_q;
    core_imag_d = core_imag_q;
    if (|rd_q) begin
      core_real_d = ch_real_a[gch_q];
      core_imag_d = ch_imag_a[gch_q];
    end
  end

  // Output steering: label each core sample with the head tag, pop on eof.
  always_comb begin
    out_cnt_d    = out_cnt_q;
    o_valid_d    = 1'b0;
    o_sof_d      = 1'b0;
    o_eof_d      = 1'b0;
    o_ch_d       = o_ch_q;
    o_real_d     = o_real_q;
    o_imag_d     = o_imag_q;
    err_orphan_d = err_orphan_q;
    tag_pop      = 1'b0;
    if (core_oen) begin
      if (tag_empty) begin
        err_orphan_d = 1'b1;
      end else begin
        o_valid_d = 1'b1;
        o_ch_d    = tag_head;
        o_real_d  = core_oreal;
        o_imag_d  = core_oimag;
        o_sof_d   = (out_cnt_q == '0);
        if (out_cnt_q == TOTAL_STEP'(N-1)) begin
          o_eof_d   = 1'b1;
          tag_pop   = 1'b1;
          out_cnt_d = '0;
        end else begin
          out_cnt_d = out_cnt_q + TOTAL_STEP'(1);
        end
      end
    end
  end

  // All state and registered outputs; reset abandons any frame in progress.
  always_ff @(posedge iclk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gch_q        <= '0;
      in_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      gnt_q        <= '0;
      rd_q         <= '0;
      core_ien_q   <= 1'b0;
      core_real_q  <= '0;
      core_imag_q  <= '0;
      out_cnt_q    <= '0;
      o_valid_q    <= 1'b0;
      o_ch_q       <= '0;
      o_sof_q      <= 1'b0;
      o_eof_q      <= 1'b0;
      o_real_q     <= '0;
      o_imag_q     <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gch_q        <= gch_d;
      in_cnt_q     <= in_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      gnt_q        <= gnt_d;
      rd_q         <= rd_d;
      core_ien_q   <= core_ien_d;
      core_real_q  <= core_real_d;
      core_imag_q  <= core_imag_d;
      out_cnt_q    <= out_cnt_d;
      o_valid_q    <= o_valid_d;
      o_ch_q       <= o_ch_d;
      o_sof_q      <= o_sof_d;
      o_eof_q      <= o_eof_d;
      o_real_q     <= o_real_d;
      o_imag_q     <= o_imag_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  assign gnt        = gnt_q;
  assign rd         = rd_q;
  assign core_ien   = core_ien_q;
  assign core_real  = core_real_q;
  assign core_imag  = core_imag_q;
  assign o_valid    = o_valid_q;
  assign o_ch       = o_ch_q;
  assign o_sof      = o_sof_q;
  assign o_eof      = o_eof_q;
  assign o_real     = o_real_q;
  assign o_imag     = o_imag_q;
  assign err_orphan = err_orphan_q;
  assign busy       = (state_q != ST_IDLE) || !tag_empty;

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares one FFT_IFFT core among NUM_CH requesters on a whole-frame basis.
- Grants one frame of FFT_MAX = 1<<TOTAL_STEP contiguous samples at a time, round-robin, and drives core ien/iReal/iImag.
- Tags every frame in flight, then steers core output (oen/oReal/oImag) back to the owning channel with start- and end-of-frame markers.
- Sits between the per-channel sample buffers and the FFT core instance.

Parameters:
- NUM_CH, 2, number of requesters (2..8).
- TOTAL_STEP, 6, FFT stages; frame length N = 1<<TOTAL_STEP.
- DATA_WIDTH, 16, real/imag sample width.
- FRAME_GAP, 0, minimum idle cycles on core ien between frames.
- TAG_DEPTH, 4, maximum frames in flight inside the core (power of 2).

Ports:
- iclk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- req  in  NUM_CH  channel k holds N samples and can deliver them back-to-back.
- gnt  out  NUM_CH  one-hot; channel k owns the current input frame.
- rd  out  NUM_CH  channel k must present a sample on ch_real/ch_imag this cycle.
- ch_real  in  NUM_CH*DATA_WIDTH  per-channel real samples, channel k at slice k.
- ch_imag  in  NUM_CH*DATA_WIDTH  per-channel imag samples.
- core_ien  out  1  to FFT core ien.
- core_real  out  DATA_WIDTH  to core iReal.
- core_imag  out  DATA_WIDTH  to core iImag.
- core_oen  in  1  from core oen.
- core_oreal  in  DATA_WIDTH  from core oReal.
- core_oimag  in  DATA_WIDTH  from core oImag.
- o_valid  out  1  result sample valid.
- o_ch  out  clog2(NUM_CH)  owning channel.
- o_sof  out  1  first sample of the result frame.
- o_eof  out  1  last sample of the result frame.
- o_real  out  DATA_WIDTH  result real.
- o_imag  out  DATA_WIDTH  result imag.
- busy  out  1  input frame in progress or tags outstanding.
- err_orphan  out  1  sticky: core_oen seen with no tag outstanding.

Behaviour:
- Reset: synchronous, rstn low on iclk rising edge. All outputs go to 0. FSM goes to IDLE, round-robin pointer to 0, tag FIFO empty, counters 0. Reset mid-frame abandons the frame: rd drops the cycle after reset is sampled, and outstanding tags are discarded.
- FSM states:
  - IDLE: if any req and tag FIFO not full, pick the first requesting channel at or after pointer (wrapping) and go to STREAM. Else stay.
  - STREAM: gnt[k] and rd[k] high for exactly N consecutive cycles. The input counter counts 0..N-1. On count N-1: push tag k, set pointer to k+1 mod NUM_CH, go to GAP if FRAME_GAP>0, else IDLE.
  - GAP: hold FRAME_GAP cycles, then IDLE.
- Arbitration cost: one IDLE cycle between frames even with FRAME_GAP=0, so the core sees a one-cycle ien gap. Requesters sample gnt the cycle it rises, and rd in the same cycle.
- req handling: req is sampled only in IDLE. Dropping req during STREAM is ignored; the frame always completes with N rd pulses.
- Input path: core_ien, core_real and core_imag are registered from the selected slice when rd[k] is high (1-cycle latency). core_ien=0 outside STREAM, and core_real/core_imag hold their last values.
- Tag FIFO: depth TAG_DEPTH. Push at the end of an input frame; pop on the last output sample.
  - Full: no new grant.
  - Simultaneous push and pop: both take effect, occupancy unchanged.
- Output path: registered, 1-cycle latency from core_oen.
  - o_valid = core_oen delayed by one cycle; o_ch = FIFO head.
  - Output counter counts oen samples 0..N-1. o_sof at count 0, o_eof at count N-1; eof pops the tag and wraps the counter to 0.
- Orphan output: core_oen with FIFO empty sets err_orphan (cleared only by reset). o_valid stays 0 for that sample.
- busy = state != IDLE or FIFO not empty.

Decomposition:
- Shared package fft_pkg: FFT_MAX computation, state encoding (IDLE/STREAM/GAP), clog2 helper for tag width.
- One sub-module: fft_tag_fifo (synchronous FIFO of clog2(NUM_CH)-bit tags with full/empty flags). Instantiated once.

Test Plan:
- Single channel, NUM_CH=2, req[0]=1 only: gnt=01 and rd[0] high for 64 cycles; core_ien high 64 cycles starting 1 cycle later; 64 o_valid with o_ch=0, o_sof on the 1st sample, o_eof on the 64th.
- Both req held high: grants alternate 0,1,0,1 with a 1-cycle ien gap. Output tags follow the same order; o_ch sequence 0,1,0,1 per frame.
- Core stub with latency > 4 frames, TAG_DEPTH=4: after 4 frames granted, no 5th gnt until the first o_eof. Grant resumes the cycle after the FIFO leaves full.
- FRAME_GAP=3: exactly 4 idle cycles on core_ien between frames (3 gap + 1 IDLE).
- req[1] dropped at sample 10 of its frame: rd[1] still asserted 64 cycles; tag 1 still pushed.
- rstn low at sample 30 of a frame: next cycle gnt=0, rd=0, core_ien=0, busy=0. A subsequent stray core_oen sets err_orphan=1, and o_valid stays 0.
